// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM state encoding,
// the row/column-to-hex key map, and small helpers used by keypad_scan_ctrl.
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  typedef logic [1:0] row_idx_t;
  typedef logic [1:0] col_idx_t;

  typedef enum logic [1:0] {
    SCAN,
    PRESS_DEB,
    HELD,
    REL_DEB
  } kp_state_t;

  // Hex value printed on each key, indexed [row][col].
  localparam logic [3:0] KEY_MAP [NUM_ROWS][NUM_COLS] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // One-cold row drive pattern for the given row index.
  function automatic logic [NUM_ROWS-1:0] row_drive(input row_idx_t r);
    return ~(NUM_ROWS'(1) << r);
  endfunction

  // Lowest-index column that reads low; caller guarantees at least one is low.
  function automatic col_idx_t lowest_low_col(input logic [NUM_COLS-1:0] c);
    col_idx_t idx;
    // NOTE: give the result a default before the loop so every path assigns it;
    // the same rule keeps combinational always blocks from inferring latches.
    idx = '0;
    for (int i = NUM_COLS - 1; i >= 0; i--) begin
      if (!c[i]) idx = col_idx_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scan_ctrl_col_sync.sv
// col_sync: two-flop synchronizer for the asynchronous, active-low column
// sense lines. Resets to all-ones (no key pressed).
module col_sync
  import keypad_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_COLS-1:0] d,
  output logic [NUM_COLS-1:0] q
);

  logic [NUM_COLS-1:0] meta;

  // Two-stage capture of the raw column lines into the clk domain.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= '1;
      q    <= '1;
    end else begin
      // NOTE: non-blocking so q takes the pre-edge meta value; blocking here
      // would collapse the two stages into a single flop.
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: scans a 4x4 matrix keypad one row at a time, debounces
// press and release of a single key, and reports it as a hex key_code with a
// one-cycle key_valid pulse. No rollover: only the first key found is tracked.
// Optional feature: define KEYPAD_AUTOREPEAT_EN to re-pulse key_valid while a
// key stays held (REPEAT_DELAY to the first repeat, then every REPEAT_PERIOD).
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 20000
`ifdef KEYPAD_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY    = 500000,
  parameter int REPEAT_PERIOD   = 100000
`endif
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_COLS-1:0] cols,
  output logic [NUM_ROWS-1:0] rows,
  output logic                key_valid,
  output logic [3:0]          key_code,
  output logic                key_held
);

  localparam int CNT_W = $clog2(max2(SCAN_DIV, DEBOUNCE_CYCLES) + 1);
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  kp_state_t           state;
  row_idx_t            row_idx;
  col_idx_t            col_idx;
  logic [CNT_W-1:0]    cnt;
  logic [NUM_COLS-1:0] scols;
  row_idx_t            next_row;

  col_sync u_col_sync (
    .clk   (clk),
    .reset (reset),
    .d     (cols),
    .q     (scols)
  );

  // Row index wraps 3 -> 0 naturally in two bits.
  assign next_row = row_idx + row_idx_t'(1);

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int REP_W = $clog2(max2(REPEAT_DELAY, REPEAT_PERIOD) + 1);

  logic [REP_W-1:0] rep_cnt;
  logic             rep_first;
  logic [REP_W-1:0] rep_target;

  // First repeat waits the long delay, later ones the shorter period.
  assign rep_target = rep_first ? REP_W'(REPEAT_DELAY - 1) : REP_W'(REPEAT_PERIOD - 1);
`endif

  // Scan/debounce FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SCAN;
      row_idx   <= '0;
      col_idx   <= '0;
      cnt       <= '0;
      rows      <= row_drive('0);
      key_valid <= 1'b0;
      key_code  <= 4'h0;
      key_held  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt   <= '0;
      rep_first <= 1'b1;
`endif
    end else begin
      key_valid <= 1'b0;
      case (state)
        SCAN: begin
          if (cnt == SCAN_LAST) begin
            cnt <= '0;
            if (scols == '1) begin
              row_idx <= next_row;
              rows    <= row_drive(next_row);
            end else begin
              col_idx <= lowest_low_col(scols);
              state   <= PRESS_DEB;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        PRESS_DEB: begin
          if (scols[col_idx]) begin
            state   <= SCAN;
            cnt     <= '0;
            row_idx <= next_row;
            rows    <= row_drive(next_row);
          end else if (cnt == DEB_LAST) begin
            state     <= HELD;
            cnt       <= '0;
            key_valid <= 1'b1;
            key_held  <= 1'b1;
            key_code  <= KEY_MAP[row_idx][col_idx];
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt   <= '0;
            rep_first <= 1'b1;
`endif
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        HELD: begin
          if (scols[col_idx]) begin
            state <= REL_DEB;
            cnt   <= '0;
          end
`ifdef KEYPAD_AUTOREPEAT_EN
          else if (rep_cnt == rep_target) begin
            key_valid <= 1'b1;
            rep_cnt   <= '0;
            rep_first <= 1'b0;
          end else begin
            rep_cnt <= rep_cnt + REP_W'(1);
          end
`endif
        end

        REL_DEB: begin
          if (!scols[col_idx]) begin
            state <= HELD;
            cnt   <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt   <= '0;
            rep_first <= 1'b1;
`endif
          end else if (cnt == DEB_LAST) begin
            state    <= SCAN;
            cnt      <= '0;
            key_held <= 1'b0;
            row_idx  <= next_row;
            rows     <= row_drive(next_row);
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        default: state <= SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with a small keypad matrix model.
// Cycle index k counts clock edges after reset is released; outputs are
// sampled on the falling edge.
`timescale 1ns/1ps
module tb_keypad_scan_ctrl;

  localparam int SCAN_DIV        = 4;
  localparam int DEBOUNCE_CYCLES = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  cols;
  logic [3:0]  rows;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_held;
  logic [15:0] pressed;  // bit r*4+c = key at (row r, col c) is down

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // Matrix: a pressed key pulls its column low while its row is driven low.
  always_comb begin
    cols = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !rows[r]) cols[c] = 1'b0;
  end

  keypad_scan_ctrl #(
    .SCAN_DIV        (SCAN_DIV),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef KEYPAD_AUTOREPEAT_EN
    ,
    .REPEAT_DELAY    (40),
    .REPEAT_PERIOD   (10)
`endif
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cols      (cols),
    .rows      (rows),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_held  (key_held)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Leaves the bench on the falling edge after the last reset edge (k = 0).
  task automatic do_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
  endtask

  task automatic release_and_wait(output int n);
    pressed = '0;
    n = 0;
    while (key_held === 1'b1 && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    pressed = '0;
    reset = 1'b1;
    repeat (3) tick();
    vectors++; if (rows !== 4'b1110) begin miscompares++; $display("FAIL reset_rows: got %b expected 1110", rows); end
    vectors++; if (key_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", key_valid); end
    vectors++; if (key_code !== 4'h0) begin miscompares++; $display("FAIL reset_code: got %h expected 0", key_code); end
    vectors++; if (key_held !== 1'b0) begin miscompares++; $display("FAIL reset_held: got %b expected 0", key_held); end
    reset = 1'b0;
  endtask

  task automatic test_idle_scan();
    logic [3:0] exp_rows;
    pressed = '0;
    do_reset();
    for (int i = 0; i < 32; i++) begin
      exp_rows = ~(4'(1) << ((i / 4) % 4));
      vectors++; if (rows !== exp_rows) begin miscompares++; $display("FAIL idle_rows k=%0d: got %b expected %b", i, rows, exp_rows); end
      vectors++; if (key_valid !== 1'b0) begin miscompares++; $display("FAIL idle_valid k=%0d: got %b expected 0", i, key_valid); end
      tick();
    end
  endtask

  task automatic test_press_5();
    int   pulses = 0;
    int   first = -1;
    logic prev_held = 1'b0;
    int   n;
    pressed = '0;
    pressed[5] = 1'b1;
    do_reset();
    for (int k = 0; k <= 40; k++) begin
      if (key_valid === 1'b1) begin
        pulses++;
        if (first < 0) begin
          first = k;
          vectors++; if (key_code !== 4'h5) begin miscompares++; $display("FAIL press5_code: got %h expected 5", key_code); end
          vectors++; if (key_held !== 1'b1 || prev_held !== 1'b0) begin miscompares++; $display("FAIL press5_held_edge: got %b->%b expected 0->1", prev_held, key_held); end
          vectors++; if (rows !== 4'b1101) begin miscompares++; $display("FAIL press5_rows: got %b expected 1101", rows); end
        end
      end
      prev_held = key_held;
      tick();
    end
    vectors++; if (pulses !== 1) begin miscompares++; $display("FAIL press5_pulses: got %0d expected 1", pulses); end
    vectors++; if (first !== 16) begin miscompares++; $display("FAIL press5_latency: got %0d expected 16", first); end
    vectors++; if (rows !== 4'b1101 || key_held !== 1'b1) begin miscompares++; $display("FAIL press5_frozen: got rows %b held %b expected 1101 1", rows, key_held); end
    release_and_wait(n);
    vectors++; if (n !== 11) begin miscompares++; $display("FAIL press5_release_time: got %0d expected 11", n); end
    vectors++; if (rows !== 4'b1011) begin miscompares++; $display("FAIL press5_resume_row: got %b expected 1011", rows); end
    vectors++; if (key_code !== 4'h5) begin miscompares++; $display("FAIL press5_code_hold: got %h expected 5", key_code); end
  endtask

  task automatic test_bounce();
    int pulses = 0;
    int first = -1;
    int n;
    pressed = '0;
    pressed[5] = 1'b1;
    do_reset();
    for (int k = 0; k <= 60; k++) begin
      if (k == 7) pressed[5] = 1'b0;
      if (k == 8) pressed[5] = 1'b1;
      if (k == 11) begin
        vectors++; if (rows !== 4'b1011) begin miscompares++; $display("FAIL bounce_abort_row: got %b expected 1011", rows); end
      end
      if (key_valid === 1'b1) begin
        pulses++;
        if (first < 0) first = k;
        vectors++; if (key_code !== 4'h5) begin miscompares++; $display("FAIL bounce_code: got %h expected 5", key_code); end
      end
      tick();
    end
    vectors++; if (pulses !== 1) begin miscompares++; $display("FAIL bounce_pulses: got %0d expected 1", pulses); end
    vectors++; if (first !== 34) begin miscompares++; $display("FAIL bounce_latency: got %0d expected 34", first); end
    release_and_wait(n);
  endtask

  task automatic test_release_glitch();
    int pulses = 0;
    int drops = 0;
    int n;
    pressed = '0;
    pressed[5] = 1'b1;
    do_reset();
    for (int k = 0; k <= 40; k++) begin
      if (k == 20) pressed[5] = 1'b0;
      if (k == 24) pressed[5] = 1'b1;
      if (key_valid === 1'b1) pulses++;
      if (k >= 16 && key_held !== 1'b1) drops++;
      tick();
    end
    vectors++; if (pulses !== 1) begin miscompares++; $display("FAIL glitch_pulses: got %0d expected 1", pulses); end
    vectors++; if (drops !== 0) begin miscompares++; $display("FAIL glitch_held_drops: got %0d expected 0", drops); end
    release_and_wait(n);
    vectors++; if (n !== 11) begin miscompares++; $display("FAIL glitch_release_time: got %0d expected 11", n); end
    vectors++; if (rows !== 4'b1011) begin miscompares++; $display("FAIL glitch_resume_row: got %b expected 1011", rows); end
  endtask

  task automatic test_reset_mid_debounce();
    int pulses = 0;
    int n;
    pressed = '0;
    pressed[5] = 1'b1;
    do_reset();
    repeat (20) tick();
    release_and_wait(n);
    vectors++; if (rows !== 4'b1011) begin miscompares++; $display("FAIL rstmid_start_row: got %b expected 1011", rows); end
    pressed[5] = 1'b1;
    for (int j = 0; j < 20; j++) begin
      tick();
      if (key_valid === 1'b1) pulses++;
    end
    vectors++; if (rows !== 4'b1101) begin miscompares++; $display("FAIL rstmid_deb_row: got %b expected 1101", rows); end
    reset = 1'b1;
    pressed = '0;
    tick();
    reset = 1'b0;
    vectors++; if (rows !== 4'b1110) begin miscompares++; $display("FAIL rstmid_rows: got %b expected 1110", rows); end
    vectors++; if (key_code !== 4'h0) begin miscompares++; $display("FAIL rstmid_code: got %h expected 0", key_code); end
    vectors++; if (key_held !== 1'b0 || key_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_flags: got held %b valid %b expected 0 0", key_held, key_valid); end
    for (int j = 0; j < 30; j++) begin
      tick();
      if (key_valid === 1'b1) pulses++;
    end
    vectors++; if (pulses !== 0) begin miscompares++; $display("FAIL rstmid_pulses: got %0d expected 0", pulses); end
    vectors++; if (rows !== 4'b0111) begin miscompares++; $display("FAIL rstmid_rescan_row: got %b expected 0111", rows); end
  endtask

  task automatic test_keymap();
    logic [15:0] masks [4] = '{16'h0008, 16'h0100, 16'h4000, 16'h0A00};
    logic [3:0]  codes [4] = '{4'hA, 4'h7, 4'hF, 4'h8};
    int          rowix [4] = '{0, 2, 3, 2};
    logic [3:0]  exp_rows;
    int          first;
    int          n;
    for (int t = 0; t < 4; t++) begin
      pressed = masks[t];
      do_reset();
      first = -1;
      exp_rows = ~(4'(1) << rowix[t]);
      for (int k = 0; k <= 40; k++) begin
        if (key_valid === 1'b1 && first < 0) begin
          first = k;
          vectors++; if (key_code !== codes[t]) begin miscompares++; $display("FAIL keymap%0d_code: got %h expected %h", t, key_code, codes[t]); end
          vectors++; if (rows !== exp_rows) begin miscompares++; $display("FAIL keymap%0d_rows: got %b expected %b", t, rows, exp_rows); end
        end
        tick();
      end
      vectors++; if (first !== 4 * rowix[t] + 12) begin miscompares++; $display("FAIL keymap%0d_latency: got %0d expected %0d", t, first, 4 * rowix[t] + 12); end
      release_and_wait(n);
      vectors++; if (key_held !== 1'b0) begin miscompares++; $display("FAIL keymap%0d_release: got held %b expected 0", t, key_held); end
    end
  endtask

  task automatic test_autorepeat();
    int times[$];
    int exp_t[$];
    int n;
`ifdef KEYPAD_AUTOREPEAT_EN
    exp_t = '{24, 64, 74, 84, 94};
`else
    exp_t = '{24};
`endif
    pressed = '0;
    pressed[15] = 1'b1;
    do_reset();
    for (int k = 0; k <= 130; k++) begin
      if (k == 99) pressed = '0;
      if (key_valid === 1'b1) begin
        times.push_back(k);
        vectors++; if (key_code !== 4'hD) begin miscompares++; $display("FAIL repeat_code k=%0d: got %h expected D", k, key_code); end
      end
      tick();
    end
    vectors++; if (times.size() !== exp_t.size()) begin miscompares++; $display("FAIL repeat_count: got %0d expected %0d", times.size(), exp_t.size()); end
    for (int i = 0; i < times.size() && i < exp_t.size(); i++) begin
      vectors++; if (times[i] !== exp_t[i]) begin miscompares++; $display("FAIL repeat_time%0d: got %0d expected %0d", i, times[i], exp_t[i]); end
    end
    release_and_wait(n);
  endtask

  initial begin
    reset = 1'b1;
    pressed = '0;
    test_reset();
    test_idle_scan();
    test_press_5();
    test_bounce();
    test_release_glitch();
    test_reset_mid_debounce();
    test_keymap();
    test_autorepeat();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation did not complete");
  end

endmodule

// File: doc/keypad_scan_ctrl.md
KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

Interface
REQ-001 SHALL use one clock; reset is synchronous and active-high.
REQ-002 Parameter SCAN_DIV, default 1000, clocks each row is driven before its columns are sampled.
REQ-003 Parameter DEBOUNCE_CYCLES, default 20000, number of consecutive stable cycles required for press or release.
REQ-004 Port clk, input, 1, system clock.
REQ-005 Port reset, input, 1, synchronous active-high reset.
REQ-006 Port cols, input, 4, raw column sense; active-low, pulled up externally; asynchronous to clk.
REQ-007 Port rows, output, 4, row drive, one-cold (exactly one bit low).
REQ-008 Port key_valid, output, 1, single-cycle pulse marking a newly debounced press.
REQ-009 Port key_code, output, 4, hex value of the last accepted key; held between events.
REQ-010 Port key_held, output, 1, high while an accepted key is down or its release is debouncing.

Function
REQ-011 SHALL pass cols through a 2-flop synchronizer; all decisions use synchronized cols (scols).
REQ-012 FSM states SHALL be SCAN, PRESS_DEB, HELD and REL_DEB.
REQ-013 SCAN: drive row r low, count SCAN_DIV cycles, sample scols on the last cycle.
- scols==4'b1111: r advances, wrapping 3->0.
- otherwise: latch r and the lowest-index low column c, then go to PRESS_DEB.
REQ-014 In PRESS_DEB, HELD and REL_DEB, rows SHALL stay frozen on the latched row.
REQ-015 PRESS_DEB: count cycles in which scols[c] is low.
- scols[c] high: return to SCAN with r advanced, counter cleared, no event.
- count reaches DEBOUNCE_CYCLES: go to HELD, pulse key_valid for exactly 1 cycle, update key_code in that same cycle.
REQ-016 Key map (row,col): r0 = 1,2,3,A; r1 = 4,5,6,B; r2 = 7,8,9,C; r3 = E,0,F,D.
REQ-017 HELD: scols[c] high SHALL go to REL_DEB with the counter cleared.
- Other columns, and keys in other rows, are ignored (no rollover).
REQ-018 REL_DEB: count consecutive cycles with scols[c] high.
- scols[c] low: return to HELD; no new key_valid.
- count reaches DEBOUNCE_CYCLES: go to SCAN with r advanced.
REQ-019 key_held SHALL be high exactly when the state is HELD or REL_DEB.
REQ-020 Counters SHALL be sized $clog2(max(SCAN_DIV, DEBOUNCE_CYCLES)+1) and SHALL never wrap.
REQ-021 Latency from a raw cols edge to a debounced key_valid SHALL be 2 (sync) + DEBOUNCE_CYCLES + 1 cycles, measured after the row's sample point.

Reset
REQ-022 Reset SHALL set state SCAN, r=0, rows=4'b1110, all counters and the synchronizer to idle (1s), key_valid=0, key_code=4'h0, key_held=0.
REQ-023 Reset asserted mid-debounce or mid-hold SHALL abort the operation with no key_valid pulse; scanning restarts at row 0 on the cycle after reset deasserts.

Configuration
REQ-024 Macro KEYPAD_AUTOREPEAT_EN SHALL control auto-repeat.
- Defined: parameters REPEAT_DELAY (default 500000) and REPEAT_PERIOD (default 100000) exist. In HELD, after REPEAT_DELAY cycles key_valid re-pulses with the same key_code, then again every REPEAT_PERIOD cycles. The repeat timer pauses in REL_DEB and clears on any return to HELD from REL_DEB.
- Undefined: no repeat logic; exactly one key_valid per debounced press.

Structure
REQ-025 Package keypad_pkg SHALL hold the state enum, the 4x4 key-map constant table, and the row-count constant (4).
REQ-026 Sub-module col_sync (2-flop, 4-bit synchronizer, reset to 4'b1111) SHALL be instantiated once; all other logic stays in keypad_scan_ctrl.

Verification (bench: SCAN_DIV=4, DEBOUNCE_CYCLES=8, REPEAT_DELAY=40, REPEAT_PERIOD=10)
REQ-027 Idle, cols=1111 for 32 cycles -> rows cycles 1110,1101,1011,0111 at 4 cycles each, then repeats; key_valid never asserts.
REQ-028 Key "5" (row1 low drives cols=1101) held 20 cycles -> one key_valid pulse with key_code=4'h5; key_held rises with the pulse; rows frozen at 1101.
REQ-029 Bounce: cols[1] low 3 cycles, high 1 cycle, low 20 cycles -> first attempt aborts; a single 4'h5 event follows the later stable period.
REQ-030 Release glitch: in HELD, cols[1] high 4 cycles then low again -> returns to HELD, no second key_valid; a final 8-cycle release then resumes scanning at row 2.
REQ-031 Reset asserted on the 5th PRESS_DEB cycle -> no key_valid; rows=1110, key_code=0 on the cycle after deassert.
REQ-032 KEYPAD_AUTOREPEAT_EN defined, key "D" held 80 cycles -> key_valid pulses with 4'hD at press, +40, +50, +60, +70 cycles; with the macro undefined, a single pulse only.
